// File: rtl/mips_bus_pkg.sv
// Shared types for the MIPS bus write buffer.
//   bus_state_t : bus front-end FSM states
//   wb_entry_t  : one queued store (word address, lane mask, data)
//   BE_WORD     : full-word byte enable used for reads
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } bus_state_t;

  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wb_entry_t;

  localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/mips_wb_fifo.sv
// Synchronous FIFO of wb_entry_t for the posted-write buffer.
//   clk_i, rst_n_i    : clock, asynchronous active-low reset (clears pointers/count)
//   push_i/push_data_i: enqueue (ignored when full)
//   pop_i             : dequeue head (ignored when empty)
//   head_o, second_o  : entry at the read pointer and the one after it
//   count_o           : occupancy, full_o / empty_o derived from it
module mips_wb_fifo
  import mips_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  wb_entry_t                push_data_i,
  input  logic                     pop_i,
  output wb_entry_t                head_o,
  output wb_entry_t                second_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  wb_entry_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] rd_ptr_nxt;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign rd_ptr_nxt = rd_ptr_q + AW'(1);
  assign head_o     = mem_q[rd_ptr_q];
  // Look-ahead entry lets the bus registers reload back-to-back on a pop.
  assign second_o   = mem_q[rd_ptr_nxt];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_nxt;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/mips_bus_write_buffer.sv
// Posted-write buffer and Avalon-MM master front end for the MIPS memory port.
//   clk, reset (async, active low)
//   req_*      : core request; req_ready is combinational acceptance
//   resp_*     : one-cycle read response
//   address, byteenable, read, write, writedata, waitrequest, readdata : Avalon-MM master
//   wb_empty   : no store queued or in flight
// Stores queue in mips_wb_fifo and drain in order; loads wait for an empty buffer.
module mips_bus_write_buffer
  import mips_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_byteenable,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [31:0] address,
  output logic [3:0]  byteenable,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [31:0] writedata,
  output logic        wb_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  bus_state_t  state_q, state_d;
  wb_entry_t   head, second, push_entry, load_entry;
  logic [AW:0] count;
  logic        full, empty;
  logic        accept, push, pop, more_after_pop, load_en;
  logic        addr_lsb_unused;

  logic [31:0] address_q, address_d;
  logic [3:0]  byteenable_q, byteenable_d;
  logic [31:0] writedata_q, writedata_d;
  logic        write_q, write_d;
  logic        read_q, read_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  // Held at 0 while reset is asserted so the core never sees an acceptance.
  assign req_ready  = reset && (req_write ? !full : (state_q == IDLE && empty));
  assign accept     = req_valid && req_ready;
  // Zero-lane stores are acknowledged but never enqueued.
  assign push       = accept && req_write && (req_byteenable != '0);
  assign pop        = (state_q == WRITE) && !waitrequest;
  assign push_entry = '{addr: req_addr[31:2], be: req_byteenable, data: req_wdata};
  assign more_after_pop  = (count > (AW+1)'(1)) || push;
  assign addr_lsb_unused = ^req_addr[1:0];

  mips_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk),
    .rst_n_i     (reset),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .second_o    (second),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!empty || push)          state_d = WRITE;
        else if (accept && !req_write) state_d = READ;
      end
      WRITE:   if (pop && !more_after_pop) state_d = IDLE;
      READ:    if (!waitrequest) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus registers load one cycle ahead: from the incoming store when the FIFO
  // is empty, and from the look-ahead entry on a back-to-back pop.
  always_comb begin
    address_d    = address_q;
    byteenable_d = byteenable_q;
    writedata_d  = writedata_q;
    write_d      = write_q;
    read_d       = read_q;
    resp_rdata_d = resp_rdata_q;
    load_en      = 1'b0;
    load_entry   = head;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          load_en = 1'b1;
        end else if (push) begin
          load_en    = 1'b1;
          load_entry = push_entry;
        end else if (accept && !req_write) begin
          address_d    = {req_addr[31:2], 2'b00};
          byteenable_d = BE_WORD;
          read_d       = 1'b1;
        end
      end
      WRITE: begin
        if (pop) begin
          if (count > (AW+1)'(1)) begin
            load_en    = 1'b1;
            load_entry = second;
          end else if (push) begin
            load_en    = 1'b1;
            load_entry = push_entry;
          end else begin
            write_d = 1'b0;
          end
        end
      end
      READ: begin
        if (!waitrequest) begin
          read_d       = 1'b0;
          resp_rdata_d = readdata;
        end
      end
      default: ;
    endcase
    if (load_en) begin
      address_d    = {load_entry.addr, 2'b00};
      byteenable_d = load_entry.be;
      writedata_d  = load_entry.data;
      write_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      address_q    <= '0;
      byteenable_q <= '0;
      writedata_q  <= '0;
      write_q      <= 1'b0;
      read_q       <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      address_q    <= address_d;
      byteenable_q <= byteenable_d;
      writedata_q  <= writedata_d;
      write_q      <= write_d;
      read_q       <= read_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign address    = address_q;
  assign byteenable = byteenable_q;
  assign writedata  = writedata_q;
  assign write      = write_q;
  assign read       = read_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_valid = (state_q == RESP);
  assign wb_empty   = empty && !write_q;

endmodule

// File: tb/tb_mips_bus_write_buffer.sv
// Self-checking bench for mips_bus_write_buffer: directed scenarios plus a
// randomized phase, all checked every cycle against a queue-based model.
module tb_mips_bus_write_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_byteenable;
  logic        req_ready, resp_valid;
  logic [31:0] resp_rdata, address, writedata, readdata;
  logic [3:0]  byteenable;
  logic        read, write, waitrequest, wb_empty;

  int total = 0;
  int bad   = 0;

  mips_bus_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (rst_n),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_byteenable (req_byteenable),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .address        (address),
    .byteenable     (byteenable),
    .read           (read),
    .write          (write),
    .waitrequest    (waitrequest),
    .readdata       (readdata),
    .writedata      (writedata),
    .wb_empty       (wb_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: stores accepted but not yet written (in order), read phase
  // (0 none, 1 bus read pending, 2 response cycle), and the one idle cycle after a response.
  typedef struct {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  int          rphase = 0;
  bit          after_resp = 1'b0;
  logic [31:0] rd_addr, rd_data;

  always @(negedge clk) begin
    bit exp_wr, exp_rdy, popped, was_resp;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      rphase     = 0;
      after_resp = 1'b0;
    end else begin
      exp_wr  = (q.size() != 0) && (rphase == 0) && !after_resp;
      exp_rdy = req_write ? (q.size() < DEPTH) : (q.size() == 0 && rphase == 0);
      chk("write",      32'(write),      32'(exp_wr));
      chk("read",       32'(read),       32'(rphase == 1));
      chk("resp_valid", 32'(resp_valid), 32'(rphase == 2));
      chk("wb_empty",   32'(wb_empty),   32'(q.size() == 0));
      chk("req_ready",  32'(req_ready),  32'(exp_rdy));
      chk("rw_excl",    32'(read && write), 32'd0);
      if (exp_wr) begin
        chk("wr_addr", address,          {q[0].a[31:2], 2'b00});
        chk("wr_be",   32'(byteenable),  32'(q[0].be));
        chk("wr_data", writedata,        q[0].d);
      end
      if (rphase == 1) begin
        chk("rd_addr", address,         {rd_addr[31:2], 2'b00});
        chk("rd_be",   32'(byteenable), 32'hF);
      end
      if (rphase == 2) chk("rd_data", resp_rdata, rd_data);

      // Advance to the state after the coming clock edge.
      popped   = exp_wr && !waitrequest;
      was_resp = (rphase == 2);
      if (rphase == 1 && !waitrequest) begin
        rd_data = readdata;
        rphase  = 2;
      end else if (rphase == 2) begin
        rphase = 0;
      end
      if (popped) void'(q.pop_front());
      if (req_valid && exp_rdy) begin
        if (req_write) begin
          if (req_byteenable != 4'h0) begin
            e.a = req_addr; e.be = req_byteenable; e.d = req_wdata;
            q.push_back(e);
          end
        end else begin
          rphase  = 1;
          rd_addr = req_addr;
        end
      end
      after_resp = was_resp;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold a request until the DUT accepts it, bounded by a cycle budget.
  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] d);
    bit acc;
    int n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_byteenable = be; req_wdata = d;
    forever begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        chk("issue_timeout", 32'd1, 32'd0);
        break;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_address"},    address,           32'd0);
    chk({pfx, "_byteenable"}, 32'(byteenable),   32'd0);
    chk({pfx, "_writedata"},  writedata,         32'd0);
    chk({pfx, "_read"},       32'(read),         32'd0);
    chk({pfx, "_write"},      32'(write),        32'd0);
    chk({pfx, "_resp_valid"}, 32'(resp_valid),   32'd0);
    chk({pfx, "_resp_rdata"}, resp_rdata,        32'd0);
    chk({pfx, "_wb_empty"},   32'(wb_empty),     32'd1);
    chk({pfx, "_req_ready"},  32'(req_ready),    32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = '0; req_byteenable = 4'hF; req_wdata = '0;
    waitrequest = 1'b0; readdata = '0;
    #2;
    chk_reset_outputs("por");
    #20 rst_n = 1'b1;
    req_valid = 1'b0;
    @(posedge clk); #1;

    // Single store
    issue(1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
    idle(3);

    // Fill the FIFO under stall, hold a fifth store while full, then drain
    waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) issue(1'b1, 32'h200 + 32'(i * 4), 4'hF, 32'hA000_0000 + 32'(i));
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h210; req_byteenable = 4'h3;
    req_wdata = 32'hA000_0004;
    idle(2);
    waitrequest = 1'b0;
    issue(1'b1, 32'h210, 4'h3, 32'hA000_0004);
    idle(8);

    // Store stalled for three cycles
    waitrequest = 1'b1;
    issue(1'b1, 32'h303, 4'h6, 32'hCAFE_F00D);
    idle(3);
    waitrequest = 1'b0;
    idle(3);

    // Load behind two pending stores
    waitrequest = 1'b1;
    issue(1'b1, 32'h500, 4'hF, 32'h1111_1111);
    issue(1'b1, 32'h504, 4'hC, 32'h2222_2222);
    waitrequest = 1'b0;
    readdata = 32'h12345678;
    issue(1'b0, 32'h204, 4'h0, 32'h0);
    idle(4);

    // Zero-lane store is dropped
    issue(1'b1, 32'h400, 4'h0, 32'h5555_5555);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      req_valid      = 1'($urandom_range(0, 1));
      req_write      = ($urandom_range(0, 3) != 0);
      req_addr       = $urandom;
      req_byteenable = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      req_wdata      = $urandom;
      waitrequest    = ($urandom_range(0, 2) == 0);
      readdata       = $urandom;
      @(posedge clk); #1;
    end
    req_valid = 1'b0; waitrequest = 1'b0;
    idle(12);

    // Reset in the middle of a stalled write with three entries queued
    waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) issue(1'b1, 32'h600 + 32'(i * 4), 4'hF, 32'hBEEF_0000 + 32'(i));
    @(posedge clk);
    #3 rst_n = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_byteenable = 4'hF;
    #1 chk_reset_outputs("midrst");
    @(posedge clk);
    #3 rst_n = 1'b1;
    req_valid = 1'b0; waitrequest = 1'b0;
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
